// File: rtl/but_filter.sv
// ---------------------------------------------------------------------------
// but_filter
//
// Button conditioning front end. Synchronises a raw, active-low, bouncing
// push-button, debounces it with a counter-qualified state machine and
// produces a clean level plus single-cycle press / release / long-press
// strobes for the downstream LED sequencer.
//
// Parameters:
//   CNT_W        width of the debounce counter
//   DEB_CYCLES   consecutive stable cycles needed to accept a level change
//                (legal range 1 .. 2**CNT_W-1)
//   LONG_W       width of the hold counter
//   LONG_CYCLES  debounced-held cycles before long_p fires
//                (legal range 1 .. 2**LONG_W-1)
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous, active-high reset
//   but_in     in   raw button, asynchronous, 0 = pressed, 1 = released
//   but_deb_o  out  debounced level, same polarity as but_in
//   press_p    out  one-cycle strobe when a press is accepted
//   release_p  out  one-cycle strobe when a release is accepted
//   long_p     out  one-cycle strobe, at most once per press
// ---------------------------------------------------------------------------
module but_filter #(
  parameter int CNT_W       = 20,
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int LONG_W      = 26,
  parameter int LONG_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic but_in,
  output logic but_deb_o,
  output logic press_p,
  output logic release_p,
  output logic long_p
);

  // Terminal values of the two counters; both counters stop here and never wrap.
  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    REL     = 2'd0,
    PRS_CHK = 2'd1,
    PRS     = 2'd2,
    REL_CHK = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;

  logic              sync1;
  logic              sync2;

  logic [CNT_W-1:0]  deb_cnt;
  logic [CNT_W-1:0]  deb_cnt_next;
  logic [LONG_W-1:0] hold_cnt;
  logic [LONG_W-1:0] hold_cnt_next;
  logic              long_done;
  logic              long_done_next;

  logic              deb_next;
  logic              press_next;
  logic              release_next;
  logic              long_next;

  // Two-flop synchroniser. Reset value is "released" so that a button held
  // down through reset cannot produce a spurious press on the first cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= but_in;
      sync2 <= sync1;
    end
  end

  // Next-state, counter and strobe logic. Bounces are tested before the
  // terminal count, so a bounce coinciding with the last counting cycle still
  // rejects the candidate level.
  always_comb begin
    state_next     = state;
    deb_cnt_next   = deb_cnt;
    hold_cnt_next  = hold_cnt;
    long_done_next = long_done;
    press_next     = 1'b0;
    release_next   = 1'b0;
    long_next      = 1'b0;

    unique case (state)
      REL: begin
        if (!sync2) begin
          state_next   = PRS_CHK;
          deb_cnt_next = '0;
        end
      end

      PRS_CHK: begin
        if (sync2) begin
          state_next   = REL;
          deb_cnt_next = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_next    = PRS;
          press_next    = 1'b1;
          hold_cnt_next = '0;
        end else begin
          deb_cnt_next = deb_cnt + CNT_W'(1);
        end
      end

      PRS: begin
        // The hold counter parks at its terminal value; long_done guarantees
        // the strobe fires only on the first cycle it is seen there.
        if (hold_cnt == LONG_LAST) begin
          if (!long_done) begin
            long_next      = 1'b1;
            long_done_next = 1'b1;
          end
        end else begin
          hold_cnt_next = hold_cnt + LONG_W'(1);
        end
        if (sync2) begin
          state_next   = REL_CHK;
          deb_cnt_next = '0;
        end
      end

      REL_CHK: begin
        // hold_cnt is frozen here, so a rejected release bounce only
        // postpones the long press instead of restarting it.
        if (!sync2) begin
          state_next = PRS;
        end else if (deb_cnt == DEB_LAST) begin
          state_next   = REL;
          release_next = 1'b1;
        end else begin
          deb_cnt_next = deb_cnt + CNT_W'(1);
        end
      end

      default: begin
        state_next   = REL;
        deb_cnt_next = '0;
      end
    endcase

    if (state_next == REL) begin
      long_done_next = 1'b0;
    end

    deb_next = (state_next == REL) || (state_next == PRS_CHK);
  end

  // State, counters and registered outputs. Outputs are loaded from the
  // next-state decode so they change on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= REL;
      deb_cnt   <= '0;
      hold_cnt  <= '0;
      long_done <= 1'b0;
      but_deb_o <= 1'b1;
      press_p   <= 1'b0;
      release_p <= 1'b0;
      long_p    <= 1'b0;
    end else begin
      state     <= state_next;
      deb_cnt   <= deb_cnt_next;
      hold_cnt  <= hold_cnt_next;
      long_done <= long_done_next;
      but_deb_o <= deb_next;
      press_p   <= press_next;
      release_p <= release_next;
      long_p    <= long_next;
    end
  end

endmodule

// File: tb/tb_but_filter.sv
// ---------------------------------------------------------------------------
// tb_but_filter
//
// Directed bench for but_filter with DEB_CYCLES=4, LONG_CYCLES=10. Each
// stimulus step pushes the output events it should cause (edge number,
// debounced level, strobes) into a scoreboard queue; a negedge monitor pops
// the event due at the current edge and compares all four outputs every
// cycle. Cycles without an event expect all strobes low and the last level.
// ---------------------------------------------------------------------------
module tb_but_filter;

  localparam int DEB  = 4;
  localparam int LONG = 10;
  localparam int LAT  = DEB + 2;

  typedef struct {
    int   at;
    logic deb;
    logic press;
    logic rel;
    logic lng;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic but_in;
  logic but_deb_o;
  logic press_p;
  logic release_p;
  logic long_p;

  int   edge_n = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic exp_deb = 1'b1;
  ev_t  sb[$];

  but_filter #(
    .CNT_W      (3),
    .DEB_CYCLES (DEB),
    .LONG_W     (4),
    .LONG_CYCLES(LONG)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .but_in   (but_in),
    .but_deb_o(but_deb_o),
    .press_p  (press_p),
    .release_p(release_p),
    .long_p   (long_p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s at edge %0d: observed %b expected %b", tag, edge_n, obs, exp);
    end
  endtask

  function automatic void expectEvent(input int at, input logic deb,
                                      input logic p, input logic r, input logic l);
    ev_t ev;
    ev.at = at; ev.deb = deb; ev.press = p; ev.rel = r; ev.lng = l;
    sb.push_back(ev);
  endfunction

  // Holds but_in at a level for n sampling edges; returns 1 time unit after
  // the last of them, so the next sampling edge is edge_n+1.
  task automatic applyStimulus(input logic level, input int n);
    but_in = level;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseReset(input int n);
    rst = 1'b1;
    expectEvent(edge_n + 1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    logic e_p, e_r, e_l;
    ev_t  ev;
    e_p = 1'b0;
    e_r = 1'b0;
    e_l = 1'b0;
    if (edge_n >= 1) begin
      if (sb.size() > 0 && sb[0].at == edge_n) begin
        ev      = sb.pop_front();
        exp_deb = ev.deb;
        e_p     = ev.press;
        e_r     = ev.rel;
        e_l     = ev.lng;
      end
      checkOutput("but_deb_o", but_deb_o, exp_deb);
      checkOutput("press_p",   press_p,   e_p);
      checkOutput("release_p", release_p, e_r);
      checkOutput("long_p",    long_p,    e_l);
    end
  end

  initial begin
    int k;
    rst    = 1'b1;
    but_in = 1'b0;

    // Reset held 3 cycles with the button down; press only after release of rst.
    $display("[TB] reset with button held");
    pulseReset(3);

    // Held 30 cycles: press, one long press, then release.
    $display("[TB] long press");
    k = edge_n + 1;
    expectEvent(k + LAT,        1'b0, 1'b1, 1'b0, 1'b0);
    expectEvent(k + LAT + LONG, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 30);
    k = edge_n + 1;
    expectEvent(k + LAT, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 12);

    // Short clean press and release.
    $display("[TB] clean press");
    k = edge_n + 1;
    expectEvent(k + LAT, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8);
    k = edge_n + 1;
    expectEvent(k + LAT, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 12);

    // Press bounce: excursions shorter than DEB are rejected.
    $display("[TB] press bounce");
    applyStimulus(1'b0, 3);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 2);
    k = edge_n + 1;
    expectEvent(k + LAT, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8);
    k = edge_n + 1;
    expectEvent(k + LAT, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 12);

    // Release bounce of 3 cycles: stays pressed, long press delayed by 3.
    $display("[TB] release bounce");
    k = edge_n + 1;
    expectEvent(k + LAT,            1'b0, 1'b1, 1'b0, 1'b0);
    expectEvent(k + LAT + LONG + 3, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8);
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 14);
    k = edge_n + 1;
    expectEvent(k + LAT, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 12);

    // Reset while counting a press (deb_cnt=2): no press, count restarts.
    $display("[TB] reset mid-count");
    k = edge_n + 1;
    applyStimulus(1'b0, 5);
    pulseReset(1);
    k = edge_n + 1;
    expectEvent(k + LAT, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8);
    k = edge_n + 1;
    expectEvent(k + LAT, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 12);

    // Reset while pressed: level returns high with no release strobe.
    $display("[TB] reset while pressed");
    k = edge_n + 1;
    expectEvent(k + LAT, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8);
    but_in = 1'b1;
    pulseReset(1);
    applyStimulus(1'b1, 12);

    vectors++;
    assert (sb.size() === 0)
    else begin
      miscompares++;
      $error("[TB] FAIL scoreboard_drain: observed %0d pending events expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
